ais_hdlc_deframer: RTL
======================

// Module: ais_hdlc_deframer
// PURPOSE
//  Downstream of the flag search window. Finds the HDLC start flag (0x7E) in the NRZI-decoded
//  bit stream, but only while i_window is high. It then de-stuffs the payload, detects the end
//  flag, the abort sequence and over-length frames, and emits payload bits plus frame markers
//  to the CRC/byte-packing stage.
// PARAMETERS
//  PAR_MAX_BITS  1024  max de-stuffed payload bits per frame (data + CRC); exceeding it is an error
//  PAR_LEN_WIDTH 11    width of o_len; must satisfy 2**PAR_LEN_WIDTH > PAR_MAX_BITS
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   synchronous reset, active-high
//  i_vld          in   1   bit strobe; i_bit and i_window are sampled only when high
//  i_bit          in   1   NRZI-decoded line bit
//  i_window       in   1   flag search window, aligned with i_bit
//  o_vld          out  1   registered copy of i_vld
//  o_bit          out  1   de-stuffed payload bit
//  o_bit_vld      out  1   o_bit is a payload bit
//  o_frame_start  out  1   1-strobe pulse: start flag accepted
//  o_frame_end    out  1   1-strobe pulse: end flag seen; o_len valid
//  o_frame_err    out  1   1-strobe pulse: abort (7 ones) or over-length
//  o_len          out  PAR_LEN_WIDTH  payload bit count; held from o_frame_end until next start
//  o_busy         out  1   high while in state FRAME
// BEHAVIOUR
//  - Reset (i_rst=1 at posedge): state=SEARCH; all outputs 0; o_len=0; history/delay/counters cleared.
//    Reset mid-frame aborts silently: no end or err pulse.
//  - Events occur only on cycles with i_vld=1. Otherwise state holds and all pulse outputs are 0.
//  - Outputs are registered. Latency is 1 clk from the i_vld cycle to the matching o_vld cycle.
//    All pulses and o_bit_vld are asserted only together with o_vld.
//  - raw[7:0]: last 8 line bits including the current one (newest in raw[0]).
//    flag = (raw == 8'h7E).
//  - SEARCH: if i_window & flag: go to FRAME, pulse o_frame_start.
//    On entry: ones=0, fill=0, cnt=0, delay line cleared. A flag with i_window=0 is ignored.
//  - FRAME, per strobe, with b = current bit:
//    * ones: counts consecutive raw ones (0..6); cleared by a 0.
//    * stuffed = (b==0 & ones==5): b enters the delay line marked "drop"; ones <= 0.
//    * end     = (b==0 & ones==6).
//    * abort   = (b==1 & ones==6): pulse o_frame_err, go to SEARCH, no bit emitted.
//    * Delay line: 8 entries (bit + drop mark), fill counter 0..8.
//      Each strobe shifts in b. If fill==8, the exiting entry is emitted
//      (o_bit_vld=1, cnt++) unless marked drop. This keeps flag bits out of the payload.
//    * On end: the exiting entry is still emitted this strobe.
//      - If cnt (after this emission) >= 8: pulse o_frame_end, o_len <= cnt, go to SEARCH.
//      - Else it is a repeated/back-to-back flag: stay in FRAME, re-init as on entry,
//        no pulse, no second o_frame_start.
//    * Over-length: if an emission would occur with cnt==PAR_MAX_BITS, the bit is not emitted.
//      Instead pulse o_frame_err and go to SEARCH.
//      An end on that same strobe is ignored, so err wins.
//  - i_window is ignored in FRAME: a frame may extend past the window.
//  - o_frame_start, o_frame_end and o_frame_err are mutually exclusive per strobe.
//  - cnt saturates logic: never exceeds PAR_MAX_BITS.
// TESTING
//  1. i_window=1, stream 7E, payload 0xA5 0x3C, 7E
//     -> o_frame_start once; 16 o_bit_vld with bits in transmit order; o_frame_end; o_len=16.
//  2. 7E with i_window=0 -> no o_frame_start, o_busy stays 0;
//     same stream with i_window=1 -> frame accepted.
//  3. Payload containing raw 1111101 (stuffed 0) -> the zero is dropped;
//     16 data bits emitted, o_len=16, no err.
//  4. After start, send 01111111 -> o_frame_err on the 7th one; state SEARCH; no o_frame_end.
//  5. PAR_MAX_BITS=16, send 17 payload bits -> 16 emitted, o_frame_err on the strobe of the
//     17th emission; back-to-back 7E 7E then data -> single o_frame_start.
//  6. Assert i_rst mid-frame, then i_vld gaps of 0..3 clks
//     -> outputs 0 after reset; o_vld tracks i_vld with 1-clk latency; results identical to gapless.

Source files
------------

// File: rtl/ais_hdlc_deframer.sv
// HDLC deframer for the AIS receive path: start-flag search gated by the
// search window, bit de-stuffing, end flag / abort / over-length detection.
// Payload bits leave through an 8-entry delay line, so the closing flag's
// bits never reach the payload output.
module ais_hdlc_deframer #(
    parameter int PAR_MAX_BITS  = 1024,
    parameter int PAR_LEN_WIDTH = 11
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_vld,
    input  logic                     i_bit,
    input  logic                     i_window,
    output logic                     o_vld,
    output logic                     o_bit,
    output logic                     o_bit_vld,
    output logic                     o_frame_start,
    output logic                     o_frame_end,
    output logic                     o_frame_err,
    output logic [PAR_LEN_WIDTH-1:0] o_len,
    output logic                     o_busy
);

    typedef enum logic {ST_SEARCH, ST_FRAME} state_t;

    localparam logic [PAR_LEN_WIDTH-1:0] CNT_MAX = PAR_LEN_WIDTH'(PAR_MAX_BITS);
    localparam logic [PAR_LEN_WIDTH-1:0] CNT_MIN = PAR_LEN_WIDTH'(8);
    localparam logic [PAR_LEN_WIDTH-1:0] CNT_ONE = PAR_LEN_WIDTH'(1);

    state_t                     state_reg, state_next;
    logic [6:0]                 raw_reg, raw_next;       // previous 7 line bits
    logic [2:0]                 ones_reg, ones_next;     // consecutive ones, 0..6
    logic [7:0]                 dly_bit_reg, dly_bit_next;   // [7] is the oldest entry
    logic [7:0]                 dly_drop_reg, dly_drop_next; // stuffed-zero marks
    logic [3:0]                 fill_reg, fill_next;     // delay line occupancy, 0..8
    logic [PAR_LEN_WIDTH-1:0]   cnt_reg, cnt_next;       // emitted payload bits
    logic [PAR_LEN_WIDTH-1:0]   len_next;
    logic                       bit_next, bit_vld_next;
    logic                       start_next, end_next, err_next;

    logic [7:0] raw_cur;
    logic       flag, stuffed, end_seen, abort_seen, emit_cand, over_len;

    assign raw_cur    = {raw_reg, i_bit};
    assign flag       = (raw_cur == 8'h7E);
    assign stuffed    = !i_bit && (ones_reg == 3'd5);
    assign end_seen   = !i_bit && (ones_reg == 3'd6);
    assign abort_seen =  i_bit && (ones_reg == 3'd6);
    assign emit_cand  = (fill_reg == 4'd8) && !dly_drop_reg[7];
    assign over_len   = emit_cand && (cnt_reg == CNT_MAX);

    // Next-state, delay line and output strobe decode for one line bit.
    always_comb begin
        state_next    = state_reg;
        raw_next      = raw_reg;
        ones_next     = ones_reg;
        dly_bit_next  = dly_bit_reg;
        dly_drop_next = dly_drop_reg;
        fill_next     = fill_reg;
        cnt_next      = cnt_reg;
        len_next      = o_len;
        bit_next      = 1'b0;
        bit_vld_next  = 1'b0;
        start_next    = 1'b0;
        end_next      = 1'b0;
        err_next      = 1'b0;
        if (i_vld) begin
            raw_next = raw_cur[6:0];
            if (state_reg == ST_SEARCH) begin
                if (i_window && flag) begin
                    state_next    = ST_FRAME;
                    start_next    = 1'b1;
                    ones_next     = 3'd0;
                    fill_next     = 4'd0;
                    cnt_next      = '0;
                    dly_bit_next  = '0;
                    dly_drop_next = '0;
                end
            end else if (abort_seen) begin
                err_next   = 1'b1;
                state_next = ST_SEARCH;
            end else begin
                ones_next     = i_bit ? (ones_reg + 3'd1) : 3'd0;
                dly_bit_next  = {dly_bit_reg[6:0], i_bit};
                dly_drop_next = {dly_drop_reg[6:0], stuffed};
                if (fill_reg != 4'd8) begin
                    fill_next = fill_reg + 4'd1;
                end
                if (over_len) begin
                    // Length overflow takes priority over a coincident end flag.
                    err_next   = 1'b1;
                    state_next = ST_SEARCH;
                end else begin
                    if (emit_cand) begin
                        bit_vld_next = 1'b1;
                        bit_next     = dly_bit_reg[7];
                        cnt_next     = cnt_reg + CNT_ONE;
                    end
                    if (end_seen) begin
                        if (cnt_next >= CNT_MIN) begin
                            end_next   = 1'b1;
                            len_next   = cnt_next;
                            state_next = ST_SEARCH;
                        end else begin
                            // Too short to be a frame: treat as a repeated flag.
                            ones_next     = 3'd0;
                            fill_next     = 4'd0;
                            cnt_next      = '0;
                            dly_bit_next  = '0;
                            dly_drop_next = '0;
                        end
                    end
                end
            end
        end
    end

    // State, history and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_SEARCH;
            raw_reg       <= '0;
            ones_reg      <= '0;
            dly_bit_reg   <= '0;
            dly_drop_reg  <= '0;
            fill_reg      <= '0;
            cnt_reg       <= '0;
            o_vld         <= 1'b0;
            o_bit         <= 1'b0;
            o_bit_vld     <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_frame_err   <= 1'b0;
            o_len         <= '0;
            o_busy        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            raw_reg       <= raw_next;
            ones_reg      <= ones_next;
            dly_bit_reg   <= dly_bit_next;
            dly_drop_reg  <= dly_drop_next;
            fill_reg      <= fill_next;
            cnt_reg       <= cnt_next;
            o_vld         <= i_vld;
            o_bit         <= bit_next;
            o_bit_vld     <= bit_vld_next;
            o_frame_start <= start_next;
            o_frame_end   <= end_next;
            o_frame_err   <= err_next;
            o_len         <= len_next;
            o_busy        <= (state_next == ST_FRAME);
        end
    end

endmodule
